uart_rx_fifo_ctrl: RTL and testbench



---
 rtl/uart_fifo_pkg.sv | 31 +++
 rtl/uart_rx_fifo_ctrl_if.sv | 36 +++
 rtl/sync_fifo_mem.sv | 93 +++++++++
 rtl/uart_rx_fifo_ctrl.sv | 143 ++++++++++++++
 tb/tb_uart_rx_fifo_ctrl.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_fifo_pkg.sv
// -----------------------------------------------------------------------------
// uart_fifo_pkg
// Shared definitions for the UART FIFO controllers (RX and TX sides):
//   - capture FSM state encoding
//   - default byte / FIFO address widths
//   - system clock and baud rate, and the idle-timeout length derived from them
// -----------------------------------------------------------------------------
package uart_fifo_pkg;

    localparam int DATA_W_DEF     = 32'd8;
    localparam int ADDR_W_DEF     = 32'd4;
    localparam int CLK_HZ         = 32'd50_000_000;
    localparam int BAUD           = 32'd9600;
    localparam int BITS_PER_CHAR  = 32'd10;   // start + 8 data + stop
    localparam int TIMEOUT_CHARS  = 32'd4;

    // Idle time of a number of character slots, in system clock cycles.
    function automatic int idle_timeout_cycles(input int clk_hz, input int baud, input int chars);
        return (clk_hz / baud) * BITS_PER_CHAR * chars;
    endfunction

    // 5208 cycles per bit * 10 bits * 4 characters = 208320
    localparam int IDLE_TIMEOUT_CYCLES = idle_timeout_cycles(CLK_HZ, BAUD, TIMEOUT_CHARS);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WRITE    = 2'd1,
        S_WAIT_LOW = 2'd2
    } cap_state_t;

endpackage

// File: rtl/uart_rx_fifo_ctrl_if.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo_ctrl_if
// Bundles the UART-receiver input and host read-side signals of the RX FIFO
// controller.
//   master : the FIFO controller (consumes RI/rx_data/rd_ready/ovr_clr,
//            drives rd_data/rd_valid/count/full/empty/overrun/timeout)
//   slave  : the surrounding logic (UART RX shifter + host)
// -----------------------------------------------------------------------------
interface uart_rx_fifo_ctrl_if
    import uart_fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              RI;
    logic [DATA_W-1:0] rx_data;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              empty;
    logic              overrun;
    logic              ovr_clr;
    logic              timeout;

    modport master (
        input  RI, rx_data, rd_ready, ovr_clr,
        output rd_data, rd_valid, count, full, empty, overrun, timeout
    );

    modport slave (
        output RI, rx_data, rd_ready, ovr_clr,
        input  rd_data, rd_valid, count, full, empty, overrun, timeout
    );
endinterface

// File: rtl/sync_fifo_mem.sv
// -----------------------------------------------------------------------------
// sync_fifo_mem
// Single-clock FIFO with first-word fall-through read.
// Ports:
//   clock, rst  : rising-edge clock, synchronous active-high reset
//   push        : write request; accepted when not full or when popping too
//   wr_data     : data written on an accepted push
//   pop         : read request; ignored while empty
//   rd_data     : head entry (valid while rd_valid)
//   rd_valid    : FIFO non-empty
//   count       : number of stored entries, 0..2**ADDR_W
//   full, empty : registered status flags, consistent with count
// Storage is not cleared by reset; only pointers and count are.
// -----------------------------------------------------------------------------
module sync_fifo_mem #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty
);
    localparam int              DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_V = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_r;
    logic [ADDR_W-1:0] rd_ptr_r;
    logic [ADDR_W:0]   count_r;
    logic              full_r;
    logic              empty_r;

    logic              pop_s;
    logic              wr_en_s;
    logic [ADDR_W:0]   count_nxt_s;

    // Qualify requests and work out the next occupancy.
    always_comb begin
        pop_s       = pop && !empty_r;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        wr_en_s     = push && (!full_r || pop_s);
        count_nxt_s = count_r;
        case ({wr_en_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointers, count and status flags.
    always_ff @(posedge clock) begin
        if (rst) begin
            wr_ptr_r <= {ADDR_W{1'b0}};
            rd_ptr_r <= {ADDR_W{1'b0}};
            count_r  <= {(ADDR_W+1){1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == DEPTH_V);
            empty_r <= (count_nxt_s == {(ADDR_W+1){1'b0}});
        end
    end

    // Storage write; contents survive reset.
    always_ff @(posedge clock) begin
        if (!rst && wr_en_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    assign rd_data  = mem_r[rd_ptr_r];
    assign rd_valid = !empty_r;
    assign count    = count_r;
    assign full     = full_r;
    assign empty    = empty_r;

endmodule

// File: rtl/uart_rx_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo_ctrl
// Receive-side FIFO controller: captures one byte per RI high period from the
// UART receiver, buffers it, and presents it to the host via valid/ready.
// Ports:
//   clock : 50 MHz system clock, rising edge
//   rst   : synchronous active-high reset
//   bus   : uart_rx_fifo_ctrl_if.master
//           RI/rx_data        from the UART RX shifter
//           rd_data/rd_valid/rd_ready  host read handshake (fall-through)
//           count/full/empty  occupancy
//           overrun/ovr_clr   sticky dropped-byte flag and its clear
//           timeout           idle-timeout indication
// Optional feature: define UART_RX_TIMEOUT_EN to build the idle counter that
// drives timeout (parameter TIMEOUT_CYCLES); otherwise timeout is tied to 0.
// -----------------------------------------------------------------------------
module uart_rx_fifo_ctrl
    import uart_fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
`ifdef UART_RX_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = IDLE_TIMEOUT_CYCLES
`endif
) (
    input  logic                clock,
    input  logic                rst,
    uart_rx_fifo_ctrl_if.master bus
);
    cap_state_t        state_r;
    logic [DATA_W-1:0] hold_r;
    logic              push_r;
    logic              overrun_r;

    logic [DATA_W-1:0] rd_data_s;
    logic              rd_valid_s;
    logic [ADDR_W:0]   count_s;
    logic              full_s;
    logic              empty_s;
    logic              pop_s;
    logic              drop_s;

    // Capture FSM: one push per RI high period, however long RI stays high.
    always_ff @(posedge clock) begin
        if (rst) begin
            state_r <= S_IDLE;
            hold_r  <= {DATA_W{1'b0}};
            push_r  <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (bus.RI) begin
                        hold_r  <= bus.rx_data;
                        push_r  <= 1'b1;
                        state_r <= S_WRITE;
                    end else begin
                        push_r  <= 1'b0;
                    end
                end
                S_WRITE: begin
                    push_r  <= 1'b0;
                    state_r <= S_WAIT_LOW;
                end
                S_WAIT_LOW: begin
                    push_r <= 1'b0;
                    if (!bus.RI) begin
                        state_r <= S_IDLE;
                    end
                end
                default: begin
                    push_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    sync_fifo_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clock    (clock),
        .rst      (rst),
        .push     (push_r),
        .wr_data  (hold_r),
        .pop      (bus.rd_ready),
        .rd_data  (rd_data_s),
        .rd_valid (rd_valid_s),
        .count    (count_s),
        .full     (full_s),
        .empty    (empty_s)
    );

    // A pop makes room, so a push onto a full FIFO is only dropped without one.
    assign pop_s  = rd_valid_s && bus.rd_ready;
    assign drop_s = push_r && full_s && !pop_s;

    // Sticky overrun flag; a new drop takes priority over the clear.
    always_ff @(posedge clock) begin
        if (rst) begin
            overrun_r <= 1'b0;
        end else if (drop_s) begin
            overrun_r <= 1'b1;
        end else if (bus.ovr_clr) begin
            overrun_r <= 1'b0;
        end
    end

`ifdef UART_RX_TIMEOUT_EN
    localparam int             CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] idle_cnt_r;
    logic             push_ok_s;

    assign push_ok_s = push_r && (!full_s || pop_s);

    // Idle counter: restarts on any FIFO activity or while empty, saturates.
    always_ff @(posedge clock) begin
        if (rst) begin
            idle_cnt_r <= {CNT_W{1'b0}};
        end else if (push_ok_s || pop_s || empty_s) begin
            idle_cnt_r <= {CNT_W{1'b0}};
        end else if (idle_cnt_r != CNT_MAX) begin
            idle_cnt_r <= idle_cnt_r + CNT_ONE;
        end
    end

    assign bus.timeout = (idle_cnt_r == CNT_MAX) && !empty_s;
`else
    assign bus.timeout = 1'b0;
`endif

    assign bus.rd_data  = rd_data_s;
    assign bus.rd_valid = rd_valid_s;
    assign bus.count    = count_s;
    assign bus.full     = full_s;
    assign bus.empty    = empty_s;
    assign bus.overrun  = overrun_r;

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fifo_ctrl
// Self-checking bench: directed scenarios plus randomized RI/read traffic,
// all checked every cycle against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_uart_rx_fifo_ctrl;
    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int TO    = 100;

    logic clock = 1'b0;
    logic rst   = 1'b1;
    always #5 clock = ~clock;

    uart_rx_fifo_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    uart_rx_fifo_ctrl #(
        .DATA_W (DW),
        .ADDR_W (AW)
`ifdef UART_RX_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (TO)
`endif
    ) dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [7:0] m_q[$];
    bit         m_ovr;
    bit         m_pend;
    logic [7:0] m_pend_byte;
    bit         m_ri_prev;
    int         m_idle;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_edge();
        bit was_empty, pop, acc;
        if (rst) begin
            m_q.delete();
            m_ovr     = 1'b0;
            m_pend    = 1'b0;
            m_ri_prev = 1'b0;
            m_idle    = 0;
            return;
        end
        was_empty = (m_q.size() == 0);
        pop       = bus.rd_ready && !was_empty;
        acc       = m_pend && ((m_q.size() < DEPTH) || pop);
        if (pop) void'(m_q.pop_front());
        if (acc) m_q.push_back(m_pend_byte);
        if (m_pend && !acc) m_ovr = 1'b1;
        else if (bus.ovr_clr) m_ovr = 1'b0;
        if (acc || pop || was_empty) m_idle = 0;
        else if (m_idle < TO) m_idle++;
        // A byte is captured at the first high sample of each RI period
        // and written into the FIFO on the following edge.
        m_pend      = bus.RI && !m_ri_prev;
        m_pend_byte = bus.rx_data;
        m_ri_prev   = bus.RI;
    endtask

    task automatic compare_all();
        bit exp_to;
`ifdef UART_RX_TIMEOUT_EN
        exp_to = (m_idle == TO) && (m_q.size() != 0);
`else
        exp_to = 1'b0;
`endif
        check_eq("count",    32'(bus.count), 32'(m_q.size()));
        check_eq("full",     32'(bus.full),  32'(m_q.size() == DEPTH));
        check_eq("empty",    32'(bus.empty), 32'(m_q.size() == 0));
        check_eq("rd_valid", 32'(bus.rd_valid), 32'(m_q.size() != 0));
        check_eq("overrun",  32'(bus.overrun), 32'(m_ovr));
        check_eq("timeout",  32'(bus.timeout), 32'(exp_to));
        if (m_q.size() != 0) check_eq("rd_data", 32'(bus.rd_data), 32'(m_q[0]));
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic pulse(input logic [7:0] d, input int hi, input int lo);
        bus.RI      = 1'b1;
        bus.rx_data = d;
        repeat (hi) step();
        bus.RI = 1'b0;
        repeat (lo) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        int ri_left;
        bus.RI       = 1'b0;
        bus.rx_data  = 8'h00;
        bus.rd_ready = 1'b0;
        bus.ovr_clr  = 1'b0;

        // Reset state
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check_eq("rst_count", 32'(bus.count), 32'd0);
        check_eq("rst_empty", 32'(bus.empty), 32'd1);
        check_eq("rst_full",  32'(bus.full),  32'd0);
        check_eq("rst_ovr",   32'(bus.overrun), 32'd0);

        // Long RI high period: exactly one push, visible after edge n+1
        bus.RI = 1'b1;
        bus.rx_data = 8'hA5;
        step();
        check_eq("lat_n_valid", 32'(bus.rd_valid), 32'd0);
        step();
        check_eq("lat_n1_valid", 32'(bus.rd_valid), 32'd1);
        check_eq("lat_n1_data",  32'(bus.rd_data),  32'hA5);
        repeat (5205) step();
        check_eq("long_ri_count", 32'(bus.count), 32'd1);
        bus.RI = 1'b0;
        repeat (3) step();

        // Three bytes, then read one per cycle in order
        do_reset();
        pulse(8'h11, 3, 2);
        pulse(8'h22, 3, 2);
        pulse(8'h33, 3, 2);
        check_eq("three_count", 32'(bus.count), 32'd3);
        check_eq("rd0", 32'(bus.rd_data), 32'h11);
        bus.rd_ready = 1'b1;
        step();
        check_eq("rd1", 32'(bus.rd_data), 32'h22);
        step();
        check_eq("rd2", 32'(bus.rd_data), 32'h33);
        step();
        check_eq("three_empty", 32'(bus.empty), 32'd1);
        step();   // rd_ready while empty: no effect
        bus.rd_ready = 1'b0;

        // Overflow: 17 pulses, 17th dropped
        for (int i = 0; i < 17; i++) begin
            pulse(8'(8'h40 + i), 2, 2);
            if (i == 15) check_eq("full_16", 32'(bus.full), 32'd1);
        end
        check_eq("ovf_ovr",   32'(bus.overrun), 32'd1);
        check_eq("ovf_count", 32'(bus.count), 32'd16);
        bus.ovr_clr = 1'b1;
        step();
        bus.ovr_clr = 1'b0;
        check_eq("ovr_clr", 32'(bus.overrun), 32'd0);
        bus.rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check_eq("ovf_read", 32'(bus.rd_data), 32'(8'(8'h40 + i)));
            step();
        end
        bus.rd_ready = 1'b0;
        check_eq("ovf_drained", 32'(bus.empty), 32'd1);

        // Full FIFO with push coincident with pop, 40 times (pointer wrap)
        for (int i = 0; i < 16; i++) pulse(8'(8'h80 + i), 2, 1);
        for (int i = 16; i < 56; i++) begin
            bus.RI = 1'b1;
            bus.rx_data = 8'(8'h80 + i);
            step();
            bus.rd_ready = 1'b1;
            step();
            bus.rd_ready = 1'b0;
            bus.RI = 1'b0;
            step();
            step();
            check_eq("coinc_count", 32'(bus.count), 32'd16);
            check_eq("coinc_ovr",   32'(bus.overrun), 32'd0);
        end
        bus.rd_ready = 1'b1;
        for (int j = 0; j < 16; j++) begin
            check_eq("wrap_read", 32'(bus.rd_data), 32'(8'(8'h80 + 40 + j)));
            step();
        end
        bus.rd_ready = 1'b0;

        // Reset while waiting for RI low with 5 bytes stored
        do_reset();
        for (int i = 0; i < 4; i++) pulse(8'(8'hC0 + i), 2, 2);
        bus.RI = 1'b1;
        bus.rx_data = 8'h55;
        step();
        step();
        check_eq("pre_rst_count", 32'(bus.count), 32'd5);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("mid_rst_count", 32'(bus.count), 32'd0);
        check_eq("mid_rst_empty", 32'(bus.empty), 32'd1);
        check_eq("mid_rst_ovr",   32'(bus.overrun), 32'd0);
        step();
        step();
        check_eq("post_rst_count", 32'(bus.count), 32'd1);
        check_eq("post_rst_data",  32'(bus.rd_data), 32'h55);
        repeat (20) step();
        check_eq("post_rst_once", 32'(bus.count), 32'd1);
        bus.RI = 1'b0;
        step();

        // Idle timeout with one byte stored
        do_reset();
        bus.RI = 1'b1;
        bus.rx_data = 8'h7E;
        step();
        step();
        bus.RI = 1'b0;
        repeat (99) step();
        check_eq("to_99", 32'(bus.timeout), 32'd0);
        step();
`ifdef UART_RX_TIMEOUT_EN
        check_eq("to_100", 32'(bus.timeout), 32'd1);
`else
        check_eq("to_100", 32'(bus.timeout), 32'd0);
`endif
        repeat (10) step();
        bus.rd_ready = 1'b1;
        step();
        bus.rd_ready = 1'b0;
        check_eq("to_pop", 32'(bus.timeout), 32'd0);

        // Randomized traffic
        do_reset();
        bus.RI  = 1'b0;
        ri_left = 1;
        for (int c = 0; c < 3000; c++) begin
            ri_left--;
            if (ri_left <= 0) begin
                bus.RI = !bus.RI;
                if (bus.RI) begin
                    bus.rx_data = 8'($urandom);
                    ri_left = int'($urandom_range(2, 6));
                end else begin
                    ri_left = int'($urandom_range(1, 5));
                end
            end
            if (c < 1500) bus.rd_ready = ($urandom_range(0, 3) == 0);
            else          bus.rd_ready = ($urandom_range(0, 3) != 0);
            bus.ovr_clr = ($urandom_range(0, 15) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
